// File: rtl/jk_ff_bank_pkg.sv
// Shared JK command encoding and next-state function for the JK flip-flop bank and its bench model.
package jk_pkg;

  typedef enum logic [1:0] {
    JK_HOLD = 2'b00,
    JK_CLR  = 2'b01,
    JK_SET  = 2'b10,
    JK_TGL  = 2'b11
  } jk_cmd_t;

  function automatic logic jk_next(jk_cmd_t cmd, logic q);
    case (cmd)
      JK_HOLD: return q;
      JK_CLR:  return 1'b0;
      JK_SET:  return 1'b1;
      default: return ~q;
    endcase
  endfunction

endpackage

// File: rtl/jk_ff_bank_if.sv
// Control/status bundle of jk_ff_bank; counter signals exist only with JK_FF_BANK_TGL_CNT_EN defined.
interface jk_ff_bank_if #(
  parameter int WIDTH = 8
`ifdef JK_FF_BANK_TGL_CNT_EN
  , parameter int CNT_W = 16
`endif
);
  logic             en;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] j;
  logic [WIDTH-1:0] k;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] q_n;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
`ifdef JK_FF_BANK_TGL_CNT_EN
  logic             cnt_clr;
  logic [CNT_W-1:0] tgl_cnt;
  logic             tgl_sat;

  modport master (output en, load, load_val, j, k, cnt_clr,
                  input  q, q_n, rise, fall, tgl_cnt, tgl_sat);
  modport slave  (input  en, load, load_val, j, k, cnt_clr,
                  output q, q_n, rise, fall, tgl_cnt, tgl_sat);
`else
  modport master (output en, load, load_val, j, k,
                  input  q, q_n, rise, fall);
  modport slave  (input  en, load, load_val, j, k,
                  output q, q_n, rise, fall);
`endif
endinterface

// File: rtl/jk_ff_bank_cell.sv
// One JK channel: state, registered complement and registered edge pulses.
// o_chg (JK_FF_BANK_TGL_CNT_EN only) flags that this edge changes q, for the bank's toggle counter.
module jk_cell
  import jk_pkg::*;
#(
  parameter logic RST_VAL = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_en,
  input  logic i_load,
  input  logic i_load_val,
  input  logic i_j,
  input  logic i_k,
  output logic o_q,
  output logic o_q_n,
  output logic o_rise,
  output logic o_fall
`ifdef JK_FF_BANK_TGL_CNT_EN
  , output logic o_chg
`endif
);

  logic r_q;
  logic r_q_n;
  logic r_rise;
  logic r_fall;
  logic w_q_next;

  // j/k are only looked at under en, so unknowns on them cannot reach q while disabled.
  always_comb begin
    w_q_next = r_q;
    if (i_load) begin
      w_q_next = i_load_val;
    end else if (i_en) begin
      w_q_next = jk_next(jk_cmd_t'({i_j, i_k}), r_q);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_q    <= RST_VAL;
      r_q_n  <= ~RST_VAL;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_q    <= w_q_next;
      r_q_n  <= ~w_q_next;
      r_rise <= ~r_q & w_q_next;
      r_fall <= r_q & ~w_q_next;
    end
  end

  assign o_q    = r_q;
  assign o_q_n  = r_q_n;
  assign o_rise = r_rise;
  assign o_fall = r_fall;
`ifdef JK_FF_BANK_TGL_CNT_EN
  assign o_chg  = r_q ^ w_q_next;
`endif

endmodule

// File: rtl/jk_ff_bank.sv
// WIDTH independent JK flip-flops with load, enable and registered rise/fall pulses.
// Define JK_FF_BANK_TGL_CNT_EN to add the saturating toggle-activity counter (cnt_clr/tgl_cnt/tgl_sat).
module jk_ff_bank
  import jk_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
`ifdef JK_FF_BANK_TGL_CNT_EN
  , parameter int             CNT_W   = 16
`endif
) (
  input  logic        i_clk,
  input  logic        i_rst,
  jk_ff_bank_if.slave bus
);

  logic [WIDTH-1:0] w_q;
  logic [WIDTH-1:0] w_q_n;
  logic [WIDTH-1:0] w_rise;
  logic [WIDTH-1:0] w_fall;
`ifdef JK_FF_BANK_TGL_CNT_EN
  logic [WIDTH-1:0] w_chg;
`endif

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
    jk_cell #(
      .RST_VAL (RST_VAL[gi])
    ) u_cell (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_en       (bus.en),
      .i_load     (bus.load),
      .i_load_val (bus.load_val[gi]),
      .i_j        (bus.j[gi]),
      .i_k        (bus.k[gi]),
      .o_q        (w_q[gi]),
      .o_q_n      (w_q_n[gi]),
      .o_rise     (w_rise[gi]),
      .o_fall     (w_fall[gi])
`ifdef JK_FF_BANK_TGL_CNT_EN
      , .o_chg    (w_chg[gi])
`endif
    );
  end

  assign bus.q    = w_q;
  assign bus.q_n  = w_q_n;
  assign bus.rise = w_rise;
  assign bus.fall = w_fall;

`ifdef JK_FF_BANK_TGL_CNT_EN
  localparam int PW = $clog2(WIDTH + 1);
  localparam int SW = ((CNT_W > PW) ? CNT_W : PW) + 1;
  localparam logic [SW-1:0] CNT_MAX = SW'({CNT_W{1'b1}});

  logic [CNT_W-1:0] r_cnt;
  logic             r_sat;
  logic [PW-1:0]    w_pop;
  logic [SW-1:0]    w_sum;

  // Counts the changes this edge commits, so the count lines up with the pulses it produces.
  always_comb begin
    w_pop = '0;
    for (int b = 0; b < WIDTH; b++) begin
      w_pop = w_pop + PW'(w_chg[b]);
    end
    w_sum = SW'(r_cnt) + SW'(w_pop);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
      r_sat <= 1'b0;
    end else if (bus.cnt_clr) begin
      r_cnt <= '0;
      r_sat <= 1'b0;
    end else if (w_sum > CNT_MAX) begin
      r_cnt <= '1;
      r_sat <= 1'b1;
    end else begin
      r_cnt <= w_sum[CNT_W-1:0];
    end
  end

  assign bus.tgl_cnt = r_cnt;
  assign bus.tgl_sat = r_sat;
`endif

endmodule
